// File: rtl/door_lock_pkg.sv
// Shared definitions for the keypad door lock.
//   lock_state_e  : controller state encoding
//   CODE_W        : width of a full 4-digit code (16 bits)
//   DIGIT_W       : width of one keypad digit (4 bits)
//   FULL_CNT      : digit count at which the entry buffer is full
//   shift_digit() : shifts a new digit into the low nibble of an entry
package door_lock_pkg;

    localparam int CODE_W  = 16;
    localparam int DIGIT_W = 4;
    localparam logic [2:0] FULL_CNT = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ENTRY   = 3'd1,
        ST_CHECK   = 3'd2,
        ST_OPEN    = 3'd3,
        ST_PROG    = 3'd4,
        ST_LOCKOUT = 3'd5
    } lock_state_e;

    function automatic logic [CODE_W-1:0] shift_digit(
        input logic [CODE_W-1:0]  cur,
        input logic [DIGIT_W-1:0] d
    );
        return {cur[CODE_W-DIGIT_W-1:0], d};
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Down-counter shared by the unlock window and the lockout period.
//   clk      in  : clock, rising edge
//   rst      in  : asynchronous active-high reset, clears the count
//   load     in  : load strobe, count <= load_val on the next edge
//   load_val in  : value to load (period length minus one)
//   zero     out : count is zero (registered count, no input-to-output path)
// When not loading, the count decrements once per cycle and holds at zero.
module lock_timer #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Keypad door lock controller: collects up to four digits, checks them
// against a stored code, opens the door for a timed window, locks the
// keypad out after repeated failures, and lets the code be changed while
// the door is open.
//   clk        in  : single clock, rising edge
//   clr        in  : asynchronous active-high reset
//   key_valid  in  : one-cycle pulse, key_code is valid this cycle
//   key_code   in  : keypad digit 0x0..0xF
//   enter      in  : one-cycle pulse, submit the entry
//   prog       in  : one-cycle pulse, change code (only honoured while open)
//   digits     out : digits entered so far, newest in [3:0]
//   digit_cnt  out : number of digits entered, 0..4
//   unlocked   out : high exactly while the door is open
//   locked_out out : high exactly while the keypad is locked out
//   fail_cnt   out : consecutive failed checks
// Input handshake: key_valid, enter and prog are fire-and-forget pulses with
// no ready/back-pressure; a pulse is consumed on the edge that samples it or
// dropped if the current state does not accept it. enter beats key_valid
// when both arrive together. Every output is a flop.
module keypad_lock_ctrl
    import door_lock_pkg::*;
#(
    parameter int unsigned       MAX_TRIES    = 3,
    parameter int unsigned       OPEN_CYCLES  = 950,
    parameter int unsigned       LOCK_CYCLES  = 1900,
    parameter logic [CODE_W-1:0] DEFAULT_CODE = 16'h1234
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                key_valid,
    input  logic [DIGIT_W-1:0]  key_code,
    input  logic                enter,
    input  logic                prog,
    output logic [CODE_W-1:0]   digits,
    output logic [2:0]          digit_cnt,
    output logic                unlocked,
    output logic                locked_out,
    output logic [1:0]          fail_cnt
);

    localparam int unsigned TMR_MAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TIMER_W = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TIMER_W-1:0] OPEN_LOAD = TIMER_W'(OPEN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCK_CYCLES - 1);
    localparam logic [1:0] TRIES = 2'(MAX_TRIES);

    lock_state_e         state_q, state_d;
    logic [CODE_W-1:0]   digits_q, digits_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [1:0]          fail_q, fail_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                unlocked_q, unlocked_d;
    logic                locked_out_q, locked_out_d;

    logic                tmr_load;
    logic [TIMER_W-1:0]  tmr_val;
    logic                tmr_zero;
    logic                key_ok;
    logic [1:0]          fail_inc;

    lock_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .rst      (clr),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        cnt_d    = cnt_q;
        fail_d   = fail_q;
        code_d   = code_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        fail_inc = fail_q + 2'd1;
        // A key arriving together with enter is discarded.
        key_ok   = key_valid && !enter;

        case (state_q)
            ST_IDLE: begin
                // IDLE always holds an empty entry, so a bare enter is ignored.
                if (key_ok) begin
                    digits_d = shift_digit(digits_q, key_code);
                    cnt_d    = 3'd1;
                    state_d  = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (enter) begin
                    state_d = ST_CHECK;
                end else if (key_ok && cnt_q != FULL_CNT) begin
                    digits_d = shift_digit(digits_q, key_code);
                    cnt_d    = cnt_q + 3'd1;
                end
            end
            ST_CHECK: begin
                // The entry is consumed whatever the outcome, so the code
                // never lingers on the display.
                digits_d = '0;
                cnt_d    = '0;
                if (cnt_q == FULL_CNT && digits_q == code_q) begin
                    fail_d   = '0;
                    tmr_load = 1'b1;
                    tmr_val  = OPEN_LOAD;
                    state_d  = ST_OPEN;
                end else begin
                    fail_d = fail_inc;
                    if (fail_inc == TRIES) begin
                        tmr_load = 1'b1;
                        tmr_val  = LOCK_LOAD;
                        state_d  = ST_LOCKOUT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_OPEN: begin
                // prog takes priority over the window expiring in the same cycle.
                if (prog) begin
                    digits_d = '0;
                    cnt_d    = '0;
                    state_d  = ST_PROG;
                end else if (tmr_zero) begin
                    digits_d = '0;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end
            end
            ST_PROG: begin
                if (enter) begin
                    if (cnt_q == FULL_CNT) begin
                        code_d = digits_q;
                    end
                    digits_d = '0;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end else if (key_ok && cnt_q != FULL_CNT) begin
                    digits_d = shift_digit(digits_q, key_code);
                    cnt_d    = cnt_q + 3'd1;
                end
            end
            ST_LOCKOUT: begin
                if (tmr_zero) begin
                    fail_d   = '0;
                    digits_d = '0;
                    cnt_d    = '0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                digits_d = '0;
                cnt_d    = '0;
                state_d  = ST_IDLE;
            end
        endcase

        // Status flags are registered from the next state so they track the
        // state register exactly, with no input-to-output path.
        unlocked_d   = (state_d == ST_OPEN);
        locked_out_d = (state_d == ST_LOCKOUT);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= ST_IDLE;
            digits_q     <= '0;
            cnt_q        <= '0;
            fail_q       <= '0;
            code_q       <= DEFAULT_CODE;
            unlocked_q   <= 1'b0;
            locked_out_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            digits_q     <= digits_d;
            cnt_q        <= cnt_d;
            fail_q       <= fail_d;
            code_q       <= code_d;
            unlocked_q   <= unlocked_d;
            locked_out_q <= locked_out_d;
        end
    end

    assign digits     = digits_q;
    assign digit_cnt  = cnt_q;
    assign unlocked   = unlocked_q;
    assign locked_out = locked_out_q;
    assign fail_cnt   = fail_q;

endmodule
